freq_meter: RTL
===============

Name: freq_meter

Overview:
- Consumer of the 1 s gate tick: counts rising edges of an external signal between consecutive tick pulses and reports frequency in Hz.
- Sits alongside the 1 s tick generator; used to measure AWG output or reference signals.
- Provides an overflow flag and an optional tick-loss watchdog.

Parameters:
- CNT_W, 24, width of edge counter and freq output.
- TIMEOUT, 24'd12999999, clk cycles without a tick before the window is declared stale (used only with TICK_TIMEOUT_EN).

Ports:
- clk  input  1  system clock (12 MHz nominal).
- rst  input  1  asynchronous reset, active-high.
- tick  input  1  gate pulse, one clk cycle wide, from the 1 s tick generator.
- sig_in  input  1  signal under measurement, asynchronous to clk.
- freq  output  CNT_W  rising-edge count of the last complete window.
- valid  output  1  one-cycle strobe: freq/ovf updated.
- ovf  output  1  last window saturated.
- stale  output  1  watchdog fired (tied 0 without TICK_TIMEOUT_EN).

Behaviour:
- Reset values: freq=0, valid=0, ovf=0, stale=0, counter=0, synchronizer regs=0, state=IDLE.
- sig_in passes through a 2-FF synchronizer, then a third register for edge detect; edge = s2 & ~s3. An edge pulse occurs 3 clk after a sig_in rise is first sampled.
- States: IDLE (no open window), MEASURE (window open).
- IDLE: counter held at 0, edges ignored; on tick -> MEASURE, counter=0, no valid strobe (the partial window after reset is discarded).
- MEASURE: each edge increments counter by 1, saturating at 2^CNT_W-1; an increment attempted at saturation sets an internal ovf_pend.
- MEASURE + tick: the next cycle has freq = counter + edge (saturating, including an edge in the tick cycle), ovf = ovf_pend or saturation on that final add, and valid=1 for exactly one cycle. Counter and ovf_pend clear to 0; state stays MEASURE. An edge in the tick cycle belongs to the closing window, never the new one.
- freq/ovf hold their values until the next valid strobe.
- Back-to-back ticks (consecutive cycles): each closes a window; the second reports the 0 or 1 edge seen in between.
- rst asserted mid-window: immediate clear of all state and outputs, return to IDLE; the first tick after release only opens a window.
- Window length is defined solely by tick spacing; the block never assumes 1 s.

Optional Feature:
- TICK_TIMEOUT_EN defined: a cycle counter runs in MEASURE and clears on each tick. When it reaches TIMEOUT without a tick: stale=1, state -> IDLE, counter cleared, no valid strobe.
- stale clears on the next valid strobe or on rst. In IDLE the timeout counter is held at 0.
- TICK_TIMEOUT_EN undefined: no timeout logic; stale tied 0; MEASURE persists indefinitely.

Test Plan:
- Window count: CNT_W=24. rst 5 cycles, tick at cycle 20 and cycle 120; sig_in rises at cycles 30,40,...,120 (10 rises, last edge pulse lands after tick at 123). Expect valid at cycle 121, freq=9, ovf=0. The rise at 120 is counted in the next window.
- First-tick discard: after rst, tick at cycle 20 with 5 prior sig_in rises. Expect no valid strobe and freq stays 0; the next tick reports only edges after cycle 20.
- Saturation: CNT_W=4, 20 rises within one window. Expect freq=15, ovf=1 with valid. A following window with 3 rises gives freq=3, ovf=0.
- Coincident edge: place a sig_in rise so its edge pulse lands exactly in the tick cycle, with 4 earlier edges. Expect freq=5, and the next window excludes that edge.
- Reset mid-window: 6 edges counted, then rst pulse, then ticks at +10 and +60 with 2 rises between. Expect no strobe at +10, then freq=2 at +61.
- Timeout (TICK_TIMEOUT_EN, TIMEOUT=50): tick then none for 60 cycles. Expect stale=1 at 50 cycles after the tick, no valid, state IDLE. A later tick pair clears stale with its valid strobe.

Source files
------------

// File: rtl/freq_meter_if.sv
// freq_meter_if: gate/signal inputs and measurement results of freq_meter.
// master = the meter (drives freq/valid/ovf/stale), slave = its user.
interface freq_meter_if #(
  parameter int CNT_W = 24
);
  logic             tick;
  logic             sig_in;
  logic [CNT_W-1:0] freq;
  logic             valid;
  logic             ovf;
  logic             stale;

  modport master (
    input  tick,
    input  sig_in,
    output freq,
    output valid,
    output ovf,
    output stale
  );

  modport slave (
    output tick,
    output sig_in,
    input  freq,
    input  valid,
    input  ovf,
    input  stale
  );
endinterface

// File: rtl/freq_meter.sv
// freq_meter: counts sig_in rising edges between gate ticks, reports Hz.
// Ports: clk, rst (async, active-high); m (freq_meter_if.master):
//   tick/sig_in in; freq/valid/ovf/stale out.
// Optional macro TICK_TIMEOUT_EN: watchdog drops a window after TIMEOUT
// clk cycles without a tick and raises stale.
module freq_meter #(
  parameter int          CNT_W   = 24,
  parameter logic [23:0] TIMEOUT = 24'd12999999
) (
  input  logic          clk,
  input  logic          rst,
  freq_meter_if.master  m
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise_p;
  logic [CNT_W-1:0] cnt;
  logic             ovf_pend;
  logic             at_max;

  // s1/s2 resynchronise sig_in; s3 delays s2 for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= m.sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_p = s2 & ~s3;
  assign at_max = (cnt == MAX);

`ifdef TICK_TIMEOUT_EN
  logic [23:0] tcnt;
  logic        tmo;
  logic        stale_q;

  // Fires on the TIMEOUT-th cycle after the last tick.
  assign tmo     = (tcnt == TIMEOUT - 24'd1);
  assign m.stale = stale_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      tcnt     <= '0;
      stale_q  <= 1'b0;
      m.freq   <= '0;
      m.valid  <= 1'b0;
      m.ovf    <= 1'b0;
    end else begin
      m.valid <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt      <= '0;
          ovf_pend <= 1'b0;
          tcnt     <= '0;
          if (m.tick) state <= MEASURE;
        end
        MEASURE: begin
          if (m.tick) begin
            // An edge in the tick cycle closes with this window.
            m.valid  <= 1'b1;
            m.freq   <= (rise_p && at_max) ? MAX
                      : cnt + (rise_p ? ONE : '0);
            m.ovf    <= ovf_pend | (rise_p & at_max);
            stale_q  <= 1'b0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            tcnt     <= '0;
          end else if (tmo) begin
            stale_q  <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            tcnt     <= '0;
          end else begin
            tcnt <= tcnt + 24'd1;
            if (rise_p) begin
              if (at_max) ovf_pend <= 1'b1;
              else        cnt      <= cnt + ONE;
            end
          end
        end
      endcase
    end
  end
`else
  assign m.stale = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      m.freq   <= '0;
      m.valid  <= 1'b0;
      m.ovf    <= 1'b0;
    end else begin
      m.valid <= 1'b0;
      unique case (state)
        IDLE: begin
          cnt      <= '0;
          ovf_pend <= 1'b0;
          if (m.tick) state <= MEASURE;
        end
        MEASURE: begin
          if (m.tick) begin
            // An edge in the tick cycle closes with this window.
            m.valid  <= 1'b1;
            m.freq   <= (rise_p && at_max) ? MAX
                      : cnt + (rise_p ? ONE : '0);
            m.ovf    <= ovf_pend | (rise_p & at_max);
            cnt      <= '0;
            ovf_pend <= 1'b0;
          end else if (rise_p) begin
            if (at_max) ovf_pend <= 1'b1;
            else        cnt      <= cnt + ONE;
          end
        end
      endcase
    end
  end
`endif

endmodule
